// File: rtl/stopwatch_ctrl_if.sv
// Command/status bundle for stopwatch_ctrl: UART byte strobe and button pulses in,
// per-channel run/clear/lap enables and the selected channel out.
interface stopwatch_ctrl_if #(
    parameter int NCH  = 4,
    parameter int SELW = 3
);
    logic [7:0]      i_rx_data;
    logic            i_rx_valid;
    logic            btnr;
    logic            btnu;
    logic            btnl;
    logic            btnd;
    logic [NCH-1:0]  o_run_on;
    logic [NCH-1:0]  o_clr_on;
    logic [NCH-1:0]  o_lap_on;
    logic [SELW-1:0] o_sel;

    modport master (
        output i_rx_data, i_rx_valid, btnr, btnu, btnl, btnd,
        input  o_run_on, o_clr_on, o_lap_on, o_sel
    );

    modport slave (
        input  i_rx_data, i_rx_valid, btnr, btnu, btnl, btnd,
        output o_run_on, o_clr_on, o_lap_on, o_sel
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Multi-channel stopwatch controller driven by UART command bytes and button pulses.
// Optional lap/freeze state is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
    parameter int         NCH         = 4,
    parameter int         SELW        = 3,
    parameter int         CLR_CYCLES  = 4,
    parameter logic [7:0] CMD_RUN     = 8'h72,
    parameter logic [7:0] CMD_STOP    = 8'h73,
    parameter logic [7:0] CMD_CLR     = 8'h63,
    parameter logic [7:0] CMD_ALLSTOP = 8'h53,
    parameter logic [7:0] CMD_LAP     = 8'h6C
) (
    input logic             clk,
    input logic             reset,
    stopwatch_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_CLR  = 2'd2,
        ST_LAP  = 2'd3
    } state_e;

    localparam int              CNTW        = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CNTW-1:0] CNT_LAST    = CNTW'(CLR_CYCLES - 1);
    localparam logic [SELW-1:0] SEL_LAST    = SELW'(NCH - 1);
    localparam logic [7:0]      DIGIT_FIRST = 8'h30;
    localparam logic [7:0]      DIGIT_LAST  = 8'(8'h30 + NCH - 1);

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    state_e          state_q [NCH];
    state_e          state_d [NCH];
    logic [CNTW-1:0] cnt_q   [NCH];
    logic [CNTW-1:0] cnt_d   [NCH];
    logic [SELW-1:0] sel_q;
    logic [SELW-1:0] sel_d;
    logic [NCH-1:0]  hit;
    logic [NCH-1:0]  run_on;
    logic [NCH-1:0]  clr_on;
    logic [NCH-1:0]  lap_on;

    logic rx_run, rx_stop, rx_clr, rx_allstop, rx_lap, rx_digit;
    logic ev_run, ev_stop, ev_clr, ev_lap;

    assign rx_run     = bus.i_rx_valid && (bus.i_rx_data == CMD_RUN);
    assign rx_stop    = bus.i_rx_valid && (bus.i_rx_data == CMD_STOP);
    assign rx_clr     = bus.i_rx_valid && (bus.i_rx_data == CMD_CLR);
    assign rx_allstop = bus.i_rx_valid && (bus.i_rx_data == CMD_ALLSTOP);
    assign rx_lap     = bus.i_rx_valid && (bus.i_rx_data == CMD_LAP);
    assign rx_digit   = bus.i_rx_valid && (bus.i_rx_data >= DIGIT_FIRST)
                                       && (bus.i_rx_data <= DIGIT_LAST);

    assign ev_run  = bus.btnr | rx_run;
    assign ev_stop = rx_stop;
    assign ev_clr  = bus.btnu | rx_clr;

`ifdef STOPWATCH_LAP_EN
    assign ev_lap = bus.btnd | rx_lap;
`else
    // Lap sources exist on the ports but have no effect in this build.
    logic unused_lap_sources;
    assign unused_lap_sources = bus.btnd | rx_lap;
    assign ev_lap = 1'b0;
`endif

    // A valid digit wins over btnl when both arrive in the same cycle.
    always_comb begin
        sel_d = sel_q;
        if (rx_digit) begin
            sel_d = SELW'(bus.i_rx_data - DIGIT_FIRST);
        end else if (bus.btnl) begin
            sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SELW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q <= '0;
            for (int k = 0; k < NCH; k++) begin
                state_q[k] <= ST_STOP;
                cnt_q[k]   <= '0;
            end
        end else begin
            sel_q <= sel_d;
            for (int k = 0; k < NCH; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

    // Local events use sel_q, so an event alongside a select change hits the old channel.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            hit[k]     = (sel_q == SELW'(k));
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            case (state_q[k])
                ST_STOP: begin
                    if (hit[k] && ev_run) begin
                        state_d[k] = ST_RUN;
                    end else if (hit[k] && ev_clr) begin
                        state_d[k] = ST_CLR;
                        cnt_d[k]   = '0;
                    end
                end
                ST_RUN: begin
                    if (rx_allstop || (hit[k] && (ev_run || ev_stop))) begin
                        state_d[k] = ST_STOP;
                    end else if (hit[k] && ev_lap) begin
                        state_d[k] = ST_LAP;
                    end
                end
                ST_LAP: begin
                    if (!LAP_EN || rx_allstop || (hit[k] && (ev_run || ev_stop))) begin
                        state_d[k] = ST_STOP;
                    end else if (hit[k] && ev_lap) begin
                        state_d[k] = ST_RUN;
                    end
                end
                ST_CLR: begin
                    if (cnt_q[k] == CNT_LAST) begin
                        state_d[k] = ST_STOP;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CNTW'(1);
                    end
                end
                default: state_d[k] = ST_STOP;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            run_on[k] = (state_q[k] == ST_RUN) || (LAP_EN && (state_q[k] == ST_LAP));
            clr_on[k] = (state_q[k] == ST_CLR);
            lap_on[k] = LAP_EN && (state_q[k] == ST_LAP);
        end
    end

    assign bus.o_run_on = run_on;
    assign bus.o_clr_on = clr_on;
    assign bus.o_lap_on = lap_on;
    assign bus.o_sel    = sel_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed testbench for stopwatch_ctrl (NCH=4, CLR_CYCLES=4); expectations are hand-computed.
module tb_stopwatch_ctrl;

    localparam int NCH  = 4;
    localparam int SELW = 3;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [14:0] exp;

    always #5 clk = ~clk;

    stopwatch_ctrl_if #(.NCH(NCH), .SELW(SELW)) bus ();

    stopwatch_ctrl #(
        .NCH(NCH),
        .SELW(SELW),
        .CLR_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Packed view {run_on, clr_on, lap_on, sel} used for every comparison.
    function automatic logic [14:0] snap();
        return {bus.o_run_on, bus.o_clr_on, bus.o_lap_on, bus.o_sel};
    endfunction

    task automatic clear_inputs();
        bus.i_rx_data  = 8'h00;
        bus.i_rx_valid = 1'b0;
        bus.btnr       = 1'b0;
        bus.btnu       = 1'b0;
        bus.btnl       = 1'b0;
        bus.btnd       = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic send(input logic [7:0] c);
        bus.i_rx_data  = c;
        bus.i_rx_valid = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.btnr = 1'b1;
        cycle();
        exp = {4'b0000, 4'b0000, 4'b0000, 3'd0};
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL reset_state: got %b expected %b", snap(), exp); end
        bus.btnu = 1'b1;
        cycle();
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL reset_hold: got %b expected %b", snap(), exp); end
        reset = 1'b0;
    endtask

    task automatic test_run_toggle();
        bus.btnr = 1'b1; cycle();
        exp = {4'b0001, 4'b0000, 4'b0000, 3'd0};
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL btnr_run: got %b expected %b", snap(), exp); end
        bus.btnr = 1'b1; cycle();
        exp = {4'b0000, 4'b0000, 4'b0000, 3'd0};
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL btnr_stop: got %b expected %b", snap(), exp); end
    endtask

    task automatic test_clear();
        bus.btnu = 1'b1; cycle();
        exp = {4'b0000, 4'b0001, 4'b0000, 3'd0};
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL clr_enter: got %b expected %b", snap(), exp); end
        for (int i = 0; i < 4; i++) begin
            bus.btnr = 1'b1; cycle();
            exp = (i < 3) ? {4'b0000, 4'b0001, 4'b0000, 3'd0} : {4'b0000, 4'b0000, 4'b0000, 3'd0};
            checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL clr_cycle%0d: got %b expected %b", i, snap(), exp); end
        end
        bus.btnr = 1'b1; cycle();
        exp = {4'b0001, 4'b0000, 4'b0000, 3'd0};
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL clr_then_run: got %b expected %b", snap(), exp); end
        bus.btnr = 1'b1; cycle();
        exp = {4'b0000, 4'b0000, 4'b0000, 3'd0};
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL clr_then_stop: got %b expected %b", snap(), exp); end
    endtask

    task automatic test_select();
        send(8'h32);
        exp = {4'b0000, 4'b0000, 4'b0000, 3'd2};
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL sel_digit2: got %b expected %b", snap(), exp); end
        send(8'h72);
        exp = {4'b0100, 4'b0000, 4'b0000, 3'd2};
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL rx_run_ch2: got %b expected %b", snap(), exp); end
        send(8'h37);
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL sel_digit7_ignored: got %b expected %b", snap(), exp); end
        bus.btnl = 1'b1; cycle();
        exp = {4'b0100, 4'b0000, 4'b0000, 3'd3};
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL btnl_inc: got %b expected %b", snap(), exp); end
        bus.btnl = 1'b1; cycle();
        exp = {4'b0100, 4'b0000, 4'b0000, 3'd0};
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL btnl_wrap: got %b expected %b", snap(), exp); end
        bus.btnr = 1'b1; send(8'h32);
        exp = {4'b0101, 4'b0000, 4'b0000, 3'd2};
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL event_old_sel: got %b expected %b", snap(), exp); end
        bus.btnl = 1'b1; send(8'h31);
        exp = {4'b0101, 4'b0000, 4'b0000, 3'd1};
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL digit_over_btnl: got %b expected %b", snap(), exp); end
    endtask

    task automatic test_allstop();
        bus.btnu = 1'b1; cycle();
        exp = {4'b0101, 4'b0010, 4'b0000, 3'd1};
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL allstop_setup: got %b expected %b", snap(), exp); end
        send(8'h53);
        exp = {4'b0000, 4'b0010, 4'b0000, 3'd1};
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL allstop_run: got %b expected %b", snap(), exp); end
        for (int i = 0; i < 3; i++) begin
            cycle();
            exp = (i < 2) ? {4'b0000, 4'b0010, 4'b0000, 3'd1} : {4'b0000, 4'b0000, 4'b0000, 3'd1};
            checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL allstop_clr%0d: got %b expected %b", i, snap(), exp); end
        end
    endtask

    task automatic test_rx_gating();
        bus.i_rx_data = 8'h72; bus.i_rx_valid = 1'b0; cycle();
        exp = {4'b0000, 4'b0000, 4'b0000, 3'd1};
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL rx_not_valid: got %b expected %b", snap(), exp); end
        send(8'h78);
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL rx_unknown_code: got %b expected %b", snap(), exp); end
        send(8'h72);
        exp = {4'b0010, 4'b0000, 4'b0000, 3'd1};
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL rx_run_ch1: got %b expected %b", snap(), exp); end
        send(8'h63);
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL clr_ignored_in_run: got %b expected %b", snap(), exp); end
        send(8'h73);
        exp = {4'b0000, 4'b0000, 4'b0000, 3'd1};
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL rx_stop_ch1: got %b expected %b", snap(), exp); end
    endtask

    task automatic test_lap();
        logic [3:0] lap_exp;
`ifdef STOPWATCH_LAP_EN
        lap_exp = 4'b0001;
`else
        lap_exp = 4'b0000;
`endif
        send(8'h30);
        bus.btnr = 1'b1; cycle();
        exp = {4'b0001, 4'b0000, 4'b0000, 3'd0};
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL lap_setup_run: got %b expected %b", snap(), exp); end
        bus.btnd = 1'b1; cycle();
        exp = {4'b0001, 4'b0000, lap_exp, 3'd0};
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL btnd_lap: got %b expected %b", snap(), exp); end
        send(8'h6C);
        exp = {4'b0001, 4'b0000, 4'b0000, 3'd0};
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL rx_lap_resume: got %b expected %b", snap(), exp); end
        bus.btnd = 1'b1; cycle();
        exp = {4'b0001, 4'b0000, lap_exp, 3'd0};
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL btnd_lap_again: got %b expected %b", snap(), exp); end
        send(8'h53);
        exp = {4'b0000, 4'b0000, 4'b0000, 3'd0};
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL allstop_from_lap: got %b expected %b", snap(), exp); end
    endtask

    task automatic test_reset_mid_clr();
        send(8'h33);
        bus.btnu = 1'b1; cycle();
        exp = {4'b0000, 4'b1000, 4'b0000, 3'd3};
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL midclr_enter: got %b expected %b", snap(), exp); end
        cycle();
        reset = 1'b1; bus.btnr = 1'b1; cycle();
        exp = {4'b0000, 4'b0000, 4'b0000, 3'd0};
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL midclr_reset: got %b expected %b", snap(), exp); end
        reset = 1'b0; cycle();
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL midclr_after_reset: got %b expected %b", snap(), exp); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] sel_exp;
        for (int i = 0; i < 4; i++) begin
            bus.btnl = 1'b1; cycle();
            sel_exp = 3'((i + 1) % 4);
            exp = {4'b0000, 4'b0000, 4'b0000, sel_exp};
            checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL btnl_seq%0d: got %b expected %b", i, snap(), exp); end
        end
        bus.btnr = 1'b1; cycle();
        bus.btnr = 1'b1; cycle();
        exp = {4'b0000, 4'b0000, 4'b0000, 3'd0};
        checks++; if (snap() !== exp) begin errors++; $display("[TB] FAIL btnr_back_to_back: got %b expected %b", snap(), exp); end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_run_toggle();
        test_clear();
        test_select();
        test_allstop();
        test_rx_gating();
        test_lap();
        test_reset_mid_clr();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NCH, 4, number of independent counter channels (1..8).
- SELW, 3, select width (>= clog2(NCH), min 1).
- CLR_CYCLES, 4, cycles a channel stays in CLR (>= 1).
- CMD_RUN, 8'h72, run/toggle code 'r'.
- CMD_STOP, 8'h73, stop code 's'.
- CMD_CLR, 8'h63, clear code 'c'.
- CMD_ALLSTOP, 8'h53, broadcast stop code 'S'.
- CMD_LAP, 8'h6C, lap code 'l'.
REQ-002 Ports (name, direction, width, meaning), one per line; one clock; reset is synchronous and active-high:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- i_rx_data, in, 8, UART receive byte.
- i_rx_valid, in, 1, one-cycle strobe; i_rx_data is decoded only when high.
- btnr, in, 1, run/stop pulse (debounced, edge-detected upstream, 1 cycle).
- btnu, in, 1, clear pulse.
- btnl, in, 1, channel-select increment pulse.
- btnd, in, 1, lap pulse.
- o_run_on, out, NCH, per-channel count enable.
- o_clr_on, out, NCH, per-channel clear.
- o_lap_on, out, NCH, per-channel display freeze.
- o_sel, out, SELW, currently selected channel.

Function
REQ-003 Per-channel 2-bit state: STOP=0, RUN=1, CLR=2, LAP=3; registered; outputs decoded combinationally from state.
REQ-004 o_run_on[k]=1 in RUN or LAP; o_clr_on[k]=1 in CLR only; o_lap_on[k]=1 in LAP only.
REQ-005 Local events (run, stop, clr, lap) apply only to channel o_sel; unselected channels hold state, except CLR timing and broadcast stop.
REQ-006 Event sources: run = btnr or valid CMD_RUN; stop = valid CMD_STOP; clr = btnu or valid CMD_CLR; lap = btnd or valid CMD_LAP.
REQ-007 STOP: run -> RUN; else clr -> CLR (run has priority); else stay.
REQ-008 RUN: run or stop -> STOP; else lap -> LAP; clr ignored.
REQ-009 LAP: run or stop -> STOP; else lap -> RUN; clr ignored.
REQ-010 CLR: all events ignored; per-channel counter loaded 0 on entry; returns to STOP after exactly CLR_CYCLES cycles with o_clr_on high.
REQ-011 Valid CMD_ALLSTOP: every channel in RUN or LAP -> STOP the next cycle; channels in STOP or CLR unaffected.
REQ-012 Valid digit byte 8'h30+k, k<NCH: o_sel=k next cycle; digits with k>=NCH and all other unlisted codes are ignored.
REQ-013 btnl: o_sel increments, wrapping NCH-1 -> 0; a valid digit in the same cycle overrides btnl.
REQ-014 An event in the same cycle as a select change applies to the old o_sel.
REQ-015 State transition latency is one clk edge after the event; no event is buffered; a pulse ignored in its state is lost.
REQ-016 Unreachable encoding (3 without LAP_EN) -> STOP next cycle; outputs 0 while in it.

Reset
REQ-017 reset high at a clk edge: all channels STOP, CLR counters 0, o_sel=0; all outputs 0 the following cycle; overrides any in-progress CLR or concurrent event.

Configuration
REQ-018 Macro STOPWATCH_LAP_EN: defined -> LAP state, btnd, CMD_LAP, and o_lap_on behave per REQ-004/008/009; undefined -> no LAP state, btnd and CMD_LAP ignored, o_lap_on tied 0, RUN leaves only on run/stop.

Verification
REQ-019 reset; btnr pulse -> o_run_on=4'b0001 next cycle; btnr again -> 4'b0000.
REQ-020 STOP, btnu pulse -> o_clr_on[0] high exactly 4 cycles, then state STOP; btnr pulses during CLR ignored.
REQ-021 rx '2' valid -> o_sel=2; rx 'r' -> o_run_on=4'b0100; rx '7' (NCH=4) -> o_sel stays 2; btnl twice -> o_sel=0.
REQ-022 ch0 and ch2 RUN, ch1 CLR; rx 'S' valid -> o_run_on=0 next cycle, ch1 completes CLR unaffected.
REQ-023 STOPWATCH_LAP_EN defined: RUN, btnd -> o_lap_on[0]=1 with o_run_on[0]=1; 'l' -> RUN; undefined: btnd -> no change.
REQ-024 'r' with i_rx_valid=0 -> no change; reset asserted mid-CLR -> all outputs 0, o_sel=0 next cycle.
